// File: rtl/gat_bram_load_ctrl.sv
// gat_bram_load_ctrl: multi-channel host-to-BRAM loader with load tracking and core run sequencing
module gat_bram_load_ctrl #(
   parameter int TOP_WIDTH = 32,
   parameter int NUM_CH    = 4,
   parameter int ADDR_W    = 18,
   parameter int DEPTH     = 242101,
   parameter int CNT_W     = ADDR_W + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH*TOP_WIDTH-1:0]   host_din,
   input  logic [NUM_CH-1:0]             host_ena,
   input  logic [NUM_CH-1:0]             host_wea,
   input  logic [NUM_CH*(ADDR_W+2)-1:0]  host_addra,
   input  logic [NUM_CH-1:0]             host_load_done,
   input  logic [NUM_CH*CNT_W-1:0]       host_expected,
   input  logic                          host_clear,
   input  logic                          core_done,
   output logic [NUM_CH*TOP_WIDTH-1:0]   bram_din,
   output logic [NUM_CH-1:0]             bram_wen,
   output logic [NUM_CH*ADDR_W-1:0]      bram_addr,
   output logic                          core_start,
   output logic [NUM_CH-1:0]             load_done,
   output logic                          gat_ready,
   output logic [TOP_WIDTH-1:0]          dbg_status
);
   typedef enum logic [1:0] {IDLE = 2'd0, LOADING = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
   localparam logic [ADDR_W:0] depth_w = (ADDR_W+1)'(DEPTH);
   state_t state, state_nxt;
   logic open_st;
   logic [NUM_CH-1:0] wr, bad, acc, done_set, ld_nxt, err_addr, err_lock;
   logic [CNT_W-1:0] wr_cnt [NUM_CH];
   logic [CNT_W-1:0] cnt_nxt [NUM_CH];
   assign open_st = (state == IDLE) || (state == LOADING);
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [ADDR_W-1:0] wa;
      logic [CNT_W-1:0] exp_cnt;
      assign wa          = host_addra[c*(ADDR_W+2)+2 +: ADDR_W];
      assign exp_cnt     = host_expected[c*CNT_W +: CNT_W];
      assign wr[c]       = host_ena[c] & host_wea[c];
      assign bad[c]      = (host_addra[c*(ADDR_W+2) +: 2] != 2'b00) || ({1'b0, wa} >= depth_w);
      assign acc[c]      = wr[c] & open_st & ~bad[c] & ~host_clear;
      assign cnt_nxt[c]  = &wr_cnt[c] ? wr_cnt[c] : wr_cnt[c] + 1'b1;
      // count-based completion sees the post-increment count so it lands with the strobe
      assign done_set[c] = open_st & (host_load_done[c] | ((exp_cnt != '0) & acc[c] & (cnt_nxt[c] == exp_cnt)));
   end
   assign ld_nxt    = load_done | done_set;
   assign gat_ready = (state == DONE);
   always_comb begin
      state_nxt = state;
      if (host_clear) state_nxt = IDLE;
      else case (state)
         IDLE:    state_nxt = &ld_nxt ? RUN : (|acc || |done_set) ? LOADING : IDLE;
         LOADING: state_nxt = &ld_nxt ? RUN : LOADING;
         RUN:     state_nxt = core_done ? DONE : RUN;
         default: state_nxt = DONE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         core_start <= 1'b0;
         load_done  <= '0;
         err_addr   <= '0;
         err_lock   <= '0;
         bram_wen   <= '0;
         bram_din   <= '0;
         bram_addr  <= '0;
         for (int i = 0; i < NUM_CH; i++) wr_cnt[i] <= '0;
      end else begin
         state      <= state_nxt;
         core_start <= (state_nxt == RUN) && (state != RUN);
         bram_wen   <= acc;
         for (int i = 0; i < NUM_CH; i++) begin
            if (acc[i]) begin
               bram_din[i*TOP_WIDTH +: TOP_WIDTH] <= host_din[i*TOP_WIDTH +: TOP_WIDTH];
               bram_addr[i*ADDR_W +: ADDR_W]      <= host_addra[i*(ADDR_W+2)+2 +: ADDR_W];
            end
         end
         if (host_clear) begin
            load_done <= '0;
            err_addr  <= '0;
            err_lock  <= '0;
            for (int i = 0; i < NUM_CH; i++) wr_cnt[i] <= '0;
         end else begin
            load_done <= ld_nxt;
            err_addr  <= err_addr | (wr & bad);
            err_lock  <= err_lock | (wr & {NUM_CH{~open_st}});
            for (int i = 0; i < NUM_CH; i++) if (acc[i]) wr_cnt[i] <= cnt_nxt[i];
         end
      end
   end
   always_comb begin
      dbg_status                            = '0;
      dbg_status[1:0]                       = state;
      dbg_status[NUM_CH+1:2]                = load_done;
      dbg_status[2*NUM_CH+1:NUM_CH+2]       = err_addr;
      dbg_status[3*NUM_CH+1:2*NUM_CH+2]     = err_lock;
      dbg_status[4*NUM_CH+1:3*NUM_CH+2]     = bram_wen;
   end
endmodule
